instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Front end of the single-issue RV32I core: holds the program counter and drives the instruction ROM address.
- Captures the combinational ROM output into the IF/ID pipeline register with a valid bit.
- Handles stall, branch/jump redirect (flush) and misaligned-target faults.
- Sits directly upstream of `InstructionMemory` (address) and also receives its `instruction` output; feeds the decode stage.

## Interface
Parameters:
- `WIDTH`, 32, datapath/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) inserted on reset/flush.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode/hazard unit requests hold of PC and IF/ID.
- `redirect`  in  1  taken branch/jump from execute; flush and load new PC.
- `redirect_target`  in  WIDTH  new PC, valid when `redirect`=1.
- `imem_address`  out  WIDTH  to ROM `address`; equals PC register.
- `imem_instruction`  in  WIDTH  from ROM `instruction`; combinational in same cycle.
- `if_pc`  out  WIDTH  PC of the instruction in IF/ID.
- `if_pc_plus4`  out  WIDTH  `if_pc`+4, for link-register writes.
- `if_instruction`  out  WIDTH  registered instruction.
- `if_valid`  out  1  IF/ID holds a real instruction, not a bubble.
- `misaligned_fault`  out  1  sticky; redirect target had bits [1:0] ≠ 0.

## Operation
- State: `pc`, IF/ID register {`if_pc`, `if_pc_plus4`, `if_instruction`, `if_valid`}, `misaligned_fault`.
- Two modes, no other FSM: RUN (`misaligned_fault`=0) and HALT (`misaligned_fault`=1).
- Per-edge priority: `rst` > HALT > `redirect` > `stall` > normal fetch.
- Reset:
  - `pc`=`RESET_PC`, `if_pc`=0, `if_pc_plus4`=0, `if_instruction`=`NOP`.
  - `if_valid`=0, `misaligned_fault`=0.
- Normal fetch:
  - IF/ID ← {`pc`, `pc`+4, `imem_instruction`, 1}.
  - `pc` ← `pc`+4.
- Stall (no redirect): `pc` and all IF/ID fields hold their values.
- Redirect with aligned target (`redirect_target[1:0]`=0):
  - `pc` ← `redirect_target`.
  - IF/ID flushed: `if_instruction`=`NOP`, `if_valid`=0; `if_pc`/`if_pc_plus4` hold.
  - `stall` is ignored that cycle, because a flush overrides a hold.
- Redirect with misaligned target:
  - `misaligned_fault` ← 1, `pc` holds, IF/ID flushed.
  - Enters HALT.
- HALT: `pc` frozen, `if_valid`=0, `if_instruction`=`NOP`; `stall` and `redirect` are ignored until `rst`.
- Arithmetic: PC increment is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- `RESET_PC` is assumed word-aligned; this is not checked.

## Timing
- `imem_address` is combinational from the `pc` register and changes only at edges.
- Fetch latency is 1 cycle:
  - instruction at PC p appears on `if_instruction` the cycle after `imem_address`=p.
- Redirect penalty:
  - redirect at edge N loads the target.
  - `if_valid`=0 for cycle N→N+1.
  - target instruction is valid after edge N+1.
- First valid instruction after reset release appears 1 edge after the first cycle with `rst`=0.
- `rst` asserted mid-stream takes effect at the next edge regardless of `stall`/`redirect`.
- Outputs are glitch-free registers except `imem_address` (register passthrough).

## Test plan
- Reset: hold `rst` 2 cycles, with ROM model returning `address`^32'hA5A5_0000.
  - During reset: `imem_address`=0, `if_valid`=0, `if_instruction`=32'h0000_0013.
  - After release: `if_instruction`=32'hA5A5_0000, `if_pc`=0, `if_pc_plus4`=4.
- Sequential: 5 free-running cycles.
  - `if_pc` = 0,4,8,C,10; `if_valid`=1 each cycle; `imem_address` leads `if_pc` by 4.
- Stall: assert `stall` for 3 cycles at `pc`=8.
  - `imem_address` stays 8; `if_pc` stays 4; `if_instruction` is unchanged.
  - After release, `if_pc`=8 follows.
- Redirect with simultaneous `stall` (`redirect_target`=32'h0000_000C, at `pc`=1C):
  - Next cycle: `imem_address`=C, `if_valid`=0, `if_instruction`=NOP.
  - Following cycle: `if_pc`=C, `if_valid`=1.
- Misaligned: `redirect_target`=32'h0000_0022.
  - `misaligned_fault`=1 and `pc` frozen at the prior value.
  - A later aligned redirect is ignored; `rst` clears the fault and restarts at 0.
- Wrap: `RESET_PC`=32'hFFFF_FFF8.
  - `imem_address` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `if_pc_plus4` for FFFF_FFFC is 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control from decode/execute, the instruction ROM port
// and the IF/ID register contents presented to decode.
// The fetch unit uses the master modport; its environment uses slave.
interface instruction_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] imem_address;
    logic [WIDTH-1:0] imem_instruction;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_pc_plus4;
    logic [WIDTH-1:0] if_instruction;
    logic             if_valid;
    logic             misaligned_fault;

    modport master (
        input  stall, redirect, redirect_target, imem_instruction,
        output imem_address, if_pc, if_pc_plus4, if_instruction, if_valid,
               misaligned_fault
    );

    modport slave (
        output stall, redirect, redirect_target, imem_instruction,
        input  imem_address, if_pc, if_pc_plus4, if_instruction, if_valid,
               misaligned_fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// captures the ROM word into the IF/ID register.
// Per-edge priority: rst > HALT > redirect > stall > normal fetch.
// Handshake: there is no valid/ready pair here; stall is a level hold
// request sampled every edge, redirect is a single-cycle strobe qualifying
// redirect_target, and if_valid marks a real instruction in IF/ID.
// misaligned_fault is the registered mode (RUN=0, HALT=1) and doubles as
// the observable FSM state.
module instruction_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } mode_t;

    mode_t            state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [WIDTH-1:0] if_instruction_q, if_instruction_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             target_misaligned;

    assign pc_plus4          = pc_q + WIDTH'(4);
    assign target_misaligned = (bus.redirect_target[1:0] != 2'b00);

    // State register: mode, PC and IF/ID, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            if_pc_q          <= '0;
            if_pc_plus4_q    <= '0;
            if_instruction_q <= NOP;
            if_valid_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_pc_q          <= if_pc_d;
            if_pc_plus4_q    <= if_pc_plus4_d;
            if_instruction_q <= if_instruction_d;
            if_valid_q       <= if_valid_d;
        end
    end

    // Next-state: HALT freezes everything, redirect flushes, stall holds.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_pc_d          = if_pc_q;
        if_pc_plus4_d    = if_pc_plus4_q;
        if_instruction_d = if_instruction_q;
        if_valid_d       = if_valid_q;
        case (state_q)
            HALT: begin
                if_instruction_d = NOP;
                if_valid_d       = 1'b0;
            end
            default: begin
                if (bus.redirect) begin
                    // A flush overrides a stall; if_pc/if_pc_plus4 keep
                    // their last values.
                    if_instruction_d = NOP;
                    if_valid_d       = 1'b0;
                    if (target_misaligned) begin
                        state_d = HALT;
                    end else begin
                        pc_d = bus.redirect_target;
                    end
                end else if (!bus.stall) begin
                    if_pc_d          = pc_q;
                    if_pc_plus4_d    = pc_plus4;
                    if_instruction_d = bus.imem_instruction;
                    if_valid_d       = 1'b1;
                    pc_d             = pc_plus4;
                end
            end
        endcase
    end

    assign bus.imem_address     = pc_q;
    assign bus.if_pc            = if_pc_q;
    assign bus.if_pc_plus4      = if_pc_plus4_q;
    assign bus.if_instruction   = if_instruction_q;
    assign bus.if_valid         = if_valid_q;
    assign bus.misaligned_fault = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP_W   = 32'h0000_0013;
    localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

    logic clk;
    logic rst;
    logic rst_w;

    int checks   = 0;
    int failures = 0;

    instruction_fetch_unit_if #(.WIDTH(32)) bus ();
    instruction_fetch_unit_if #(.WIDTH(32)) bus_w ();

    // ROM models: word at address a is a ^ A5A5_0000.
    assign bus.imem_instruction   = bus.imem_address ^ ROM_KEY;
    assign bus_w.imem_instruction = bus_w.imem_address ^ ROM_KEY;

    instruction_fetch_unit #(
        .WIDTH(32), .RESET_PC(32'h0000_0000), .NOP(NOP_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    instruction_fetch_unit #(
        .WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP(NOP_W)
    ) dut_w (
        .clk(clk), .rst(rst_w), .bus(bus_w)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_if_pc, m_if_pc4, m_ins;
    logic        m_val, m_fault;

    task automatic model_edge(input logic r, input logic s, input logic rd,
                              input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_if_pc = 32'h0; m_if_pc4 = 32'h0;
            m_ins = NOP_W; m_val = 1'b0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_ins = NOP_W; m_val = 1'b0;
        end else if (rd) begin
            m_ins = NOP_W; m_val = 1'b0;
            if (t % 4 != 0) m_fault = 1'b1;
            else            m_pc = t;
        end else if (!s) begin
            m_if_pc  = m_pc;
            m_if_pc4 = m_pc + 32'd4;
            m_ins    = m_pc ^ ROM_KEY;
            m_val    = 1'b1;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("imem_address",     bus.imem_address,          m_pc);
        check("if_pc",            bus.if_pc,                 m_if_pc);
        check("if_pc_plus4",      bus.if_pc_plus4,           m_if_pc4);
        check("if_instruction",   bus.if_instruction,        m_ins);
        check("if_valid",         {31'b0, bus.if_valid},     {31'b0, m_val});
        check("misaligned_fault", {31'b0, bus.misaligned_fault}, {31'b0, m_fault});
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic s, input logic rd,
                         input logic [31:0] t);
        rst                 = r;
        bus.stall           = s;
        bus.redirect        = rd;
        bus.redirect_target = t;
        @(posedge clk);
        model_edge(r, s, rd, t);
        #1;
        check_all();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] prior_pc;
    logic [31:0] tgt;
    logic        r_r, r_s, r_rd;

    initial begin
        rst                   = 1'b1;
        rst_w                 = 1'b1;
        bus.stall             = 1'b0;
        bus.redirect          = 1'b0;
        bus.redirect_target   = 32'h0;
        bus_w.stall           = 1'b0;
        bus_w.redirect        = 1'b0;
        bus_w.redirect_target = 32'h0;

        // Reset held two cycles.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_addr",  bus.imem_address, 32'h0);
        check("rst_valid", {31'b0, bus.if_valid}, 32'h0);
        check("rst_nop",   bus.if_instruction, 32'h0000_0013);

        // First fetch after release, then free-run.
        cycle(0, 0, 0, 0);
        check("first_ins",  bus.if_instruction, 32'hA5A5_0000);
        check("first_pc",   bus.if_pc, 32'h0);
        check("first_pc4",  bus.if_pc_plus4, 32'h4);
        for (int i = 1; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            check("seq_pc",   bus.if_pc, 32'(i * 4));
            check("seq_lead", bus.imem_address, bus.if_pc + 32'd4);
        end

        // Stall three cycles at pc=8.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            check("stall_addr", bus.imem_address, 32'h8);
            check("stall_pc",   bus.if_pc, 32'h4);
            check("stall_ins",  bus.if_instruction, 32'h4 ^ ROM_KEY);
        end
        cycle(0, 0, 0, 0);
        check("unstall_pc", bus.if_pc, 32'h8);

        // Run up to pc=1C (bounded), then redirect with stall held.
        for (int i = 0; i < 20 && m_pc != 32'h1C; i++) cycle(0, 0, 0, 0);
        check("reach_1c", bus.imem_address, 32'h1C);
        cycle(0, 1, 1, 32'h0000_000C);
        check("redir_addr",  bus.imem_address, 32'hC);
        check("redir_valid", {31'b0, bus.if_valid}, 32'h0);
        check("redir_nop",   bus.if_instruction, NOP_W);
        cycle(0, 0, 0, 0);
        check("redir_pc",    bus.if_pc, 32'hC);
        check("redir_valid2", {31'b0, bus.if_valid}, 32'h1);

        // Misaligned redirect, later aligned redirect ignored, reset recovers.
        prior_pc = bus.imem_address;
        cycle(0, 0, 1, 32'h0000_0022);
        check("mis_fault", {31'b0, bus.misaligned_fault}, 32'h1);
        check("mis_pc",    bus.imem_address, prior_pc);
        cycle(0, 0, 1, 32'h0000_0040);
        check("halt_pc",   bus.imem_address, prior_pc);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check("clr_fault", {31'b0, bus.misaligned_fault}, 32'h0);
        check("clr_addr",  bus.imem_address, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r_r  = ($urandom_range(0, 99) < 3);
            r_s  = ($urandom_range(0, 99) < 25);
            r_rd = ($urandom_range(0, 99) < 12);
            tgt  = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 99) < 15) tgt = tgt | 32'($urandom_range(1, 3));
            cycle(r_r, r_s, r_rd, tgt);
        end

        // Wrap instance: RESET_PC = FFFF_FFF8.
        rst_w = 1'b1;
        cycle(0, 0, 0, 0);
        check("wrap_a0", bus_w.imem_address, 32'hFFFF_FFF8);
        rst_w = 1'b0;
        cycle(0, 0, 0, 0);
        check("wrap_a1", bus_w.imem_address, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        check("wrap_a2",   bus_w.imem_address, 32'h0000_0000);
        check("wrap_pc",   bus_w.if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4",  bus_w.if_pc_plus4, 32'h0000_0000);
        check("wrap_ins",  bus_w.if_instruction, 32'hFFFF_FFFC ^ ROM_KEY);
        check("wrap_flag", {31'b0, bus_w.misaligned_fault}, 32'h0);

        // Final report.
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
